// File: rtl/cpu_boot_controller_if.sv
// Signal bundle between the chip-level boot I/O and the boot controller.
// The controller takes the slave side; whoever drives the boot sequence
// (chip pins or a bench) takes the master side.
interface cpu_boot_controller_if #(
  parameter int ADD_WIDTH = 7,
  parameter int RUN_WIDTH = 16
);
  logic                 start;
  logic                 abort;
  logic [ADD_WIDTH:0]   load_len;
  logic [RUN_WIDTH-1:0] run_cycles;
  logic [7:0]           byte_in;
  logic                 byte_valid;
  logic                 byte_ready;
  logic                 pm_wr_en;
  logic [ADD_WIDTH-1:0] pm_addr;
  logic [7:0]           pm_wdata;
  logic                 cpu_rst;
  logic [7:0]           alu_result;
  logic [7:0]           result_out;
  logic                 result_valid;
  logic                 busy;

  modport master (
    output start, abort, load_len, run_cycles, byte_in, byte_valid, alu_result,
    input  byte_ready, pm_wr_en, pm_addr, pm_wdata, cpu_rst, result_out,
           result_valid, busy
  );

  modport slave (
    input  start, abort, load_len, run_cycles, byte_in, byte_valid, alu_result,
    output byte_ready, pm_wr_en, pm_addr, pm_wdata, cpu_rst, result_out,
           result_valid, busy
  );
endinterface

// File: rtl/cpu_boot_controller.sv
// Boot sequencer for the RISC-V core: streams a program image into program
// memory, releases the core from reset for a set number of cycles, captures
// the ALU result on the final run cycle and parks the core in reset again.
// Every output is a register whose next value is decoded from the next state.
module cpu_boot_controller #(
  parameter int ADD_WIDTH = 7,
  parameter int RUN_WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  cpu_boot_controller_if.slave bus
);
  localparam logic [ADD_WIDTH:0]   LEN_MAX  = {1'b1, {ADD_WIDTH{1'b0}}};
  localparam logic [ADD_WIDTH:0]   LEN_ONE  = {{ADD_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADD_WIDTH:0]   LEN_ZERO = {(ADD_WIDTH+1){1'b0}};
  localparam logic [ADD_WIDTH-1:0] ADDR_ONE = {{(ADD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RUN_WIDTH-1:0] RUN_ONE  = {{(RUN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RUN_WIDTH-1:0] RUN_ZERO = {RUN_WIDTH{1'b0}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    RUN   = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t state, state_next;

  // Sequence parameters and progress counters
  logic [ADD_WIDTH:0]   len_q;
  logic [RUN_WIDTH-1:0] cycles_q;
  logic [RUN_WIDTH-1:0] run_cnt;
  logic [ADD_WIDTH-1:0] count;

  // Output registers and their next values
  logic                 ready_q, wr_en_q, cpu_rst_q, busy_q, valid_q;
  logic [ADD_WIDTH-1:0] addr_q;
  logic [7:0]           wdata_q, result_q;
  logic                 ready_d, wr_en_d, cpu_rst_d, busy_d, valid_d;
  logic [ADD_WIDTH-1:0] addr_d;
  logic [7:0]           wdata_d, result_d;

  logic               start_ok, handshake, last_byte, entering_halt;
  logic [ADD_WIDTH:0] clip_len;

  // Qualify start/handshake events and clip the requested image length
  always_comb begin
    start_ok  = bus.start && !bus.abort && ((state == IDLE) || (state == HALT));
    // An abort in the same cycle swallows the byte so no write follows it
    handshake = ready_q && bus.byte_valid && !bus.abort;
    last_byte = handshake && ({1'b0, count} == (len_q - LEN_ONE));
    if (bus.load_len > LEN_MAX) begin
      clip_len = LEN_MAX;
    end else begin
      clip_len = bus.load_len;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; abort overrides everything including start
  always_comb begin
    state_next = state;
    if (bus.abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (!start_ok) begin
            state_next = state;
          end else if (clip_len != LEN_ZERO) begin
            state_next = LOAD;
          end else if (bus.run_cycles != RUN_ZERO) begin
            state_next = RUN;
          end else begin
            state_next = HALT;
          end
        end
        LOAD: begin
          if (last_byte) begin
            state_next = DRAIN;
          end else begin
            state_next = LOAD;
          end
        end
        DRAIN: begin
          if (cycles_q != RUN_ZERO) begin
            state_next = RUN;
          end else begin
            state_next = HALT;
          end
        end
        RUN: begin
          if (run_cnt == RUN_ONE) begin
            state_next = HALT;
          end else begin
            state_next = RUN;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Next output values, decoded from the state being entered
  always_comb begin
    // A restart from HALT straight back into HALT still counts as a fresh capture
    entering_halt = (state_next == HALT) && ((state != HALT) || start_ok);
    ready_d   = (state_next == LOAD);
    busy_d    = (state_next == LOAD) || (state_next == DRAIN) || (state_next == RUN);
    cpu_rst_d = (state_next != RUN);
    valid_d   = (state_next == HALT);
    wr_en_d   = handshake;
    if (handshake) begin
      addr_d  = count;
      wdata_d = bus.byte_in;
    end else begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
    end
    // Zero-cycle runs report a cleared result rather than a stale one
    if (entering_halt) begin
      result_d = (state == RUN) ? bus.alu_result : 8'h00;
    end else begin
      result_d = result_q;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      addr_q    <= {ADD_WIDTH{1'b0}};
      wdata_q   <= 8'h00;
      result_q  <= 8'h00;
    end else begin
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      result_q  <= result_d;
    end
  end

  // Latch sequence parameters on start, advance byte and run counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= LEN_ZERO;
      cycles_q <= RUN_ZERO;
      run_cnt  <= RUN_ZERO;
      count    <= {ADD_WIDTH{1'b0}};
    end else if (start_ok) begin
      len_q    <= clip_len;
      cycles_q <= bus.run_cycles;
      run_cnt  <= bus.run_cycles;
      count    <= {ADD_WIDTH{1'b0}};
    end else begin
      if (handshake) begin
        count <= count + ADDR_ONE;
      end
      if (state == DRAIN) begin
        run_cnt <= cycles_q;
      end else if (state == RUN) begin
        run_cnt <= run_cnt - RUN_ONE;
      end
    end
  end

  assign bus.byte_ready   = ready_q;
  assign bus.pm_wr_en     = wr_en_q;
  assign bus.pm_addr      = addr_q;
  assign bus.pm_wdata     = wdata_q;
  assign bus.cpu_rst      = cpu_rst_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.result_out   = result_q;
endmodule

// File: tb/tb_cpu_boot_controller.sv
// Self-checking bench for cpu_boot_controller. Each sequence is planned as a
// timeline: handshake cycles come from the valid pattern, and the DRAIN, RUN
// and HALT windows follow from the last handshake and the run length.
module tb_cpu_boot_controller;
  localparam int AW   = 7;
  localparam int RW   = 16;
  localparam int MAXC = 1024;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cpu_boot_controller_if #(.ADD_WIDTH(AW), .RUN_WIDTH(RW)) bus ();

  cpu_boot_controller #(.ADD_WIDTH(AW), .RUN_WIDTH(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Planned stimulus per cycle (cycle 0 carries the start pulse)
  bit         v_plan[MAXC];
  logic [7:0] byte_plan[MAXC];
  logic [7:0] alu_plan[MAXC];
  int         hs_idx[MAXC];
  logic [7:0] fixed_bytes[4];
  bit         use_fixed = 1'b0;
  logic [7:0] prev_result = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_ready"}, bus.byte_ready, 0);
    check_eq({tag, "_wr_en"}, bus.pm_wr_en, 0);
    check_eq({tag, "_addr"}, bus.pm_addr, 0);
    check_eq({tag, "_wdata"}, bus.pm_wdata, 0);
    check_eq({tag, "_cpu_rst"}, bus.cpu_rst, 1);
    check_eq({tag, "_result"}, bus.result_out, 0);
    check_eq({tag, "_valid"}, bus.result_valid, 0);
    check_eq({tag, "_busy"}, bus.busy, 0);
  endtask

  // gap_mode: 0 back-to-back, 1 random gaps, 2 pattern 1,0,0,1,1
  // abort_mode: 0 none, 1 second RUN cycle, 2 random cycle up to HALT
  task automatic run_seq(input int len_in, input int ncyc, input int gap_mode,
                         input int abort_mode, input bit mid_start);
    int L, k, hlast, r, halt, a, m, last_c, e;
    logic [7:0] res_exp, exp_res;
    bit exp_ready, exp_wr, exp_rst, exp_busy, exp_valid;
    L = (len_in > 128) ? 128 : len_in;
    for (int c = 0; c < MAXC; c++) begin
      byte_plan[c] = 8'($urandom);
      alu_plan[c]  = 8'($urandom);
      hs_idx[c]    = -1;
      case (gap_mode)
        0:       v_plan[c] = (c >= 1);
        1:       v_plan[c] = (c >= 1) && (($urandom_range(0, 2) != 0) || (c > 300));
        default: v_plan[c] = (c == 1) || (c == 4) || (c == 5);
      endcase
    end
    k = 0;
    hlast = 0;
    for (int c = 1; c < MAXC && k < L; c++) begin
      if (v_plan[c]) begin
        hs_idx[c] = k;
        if (use_fixed && k < 4) byte_plan[c] = fixed_bytes[k];
        k++;
        hlast = c;
      end
    end
    r       = (L > 0) ? hlast + 2 : 1;
    halt    = r + ncyc;
    res_exp = (ncyc > 0) ? alu_plan[r + ncyc - 1] : 8'h00;
    a = -1;
    if (abort_mode == 1) a = r + 1;
    else if (abort_mode == 2) a = $urandom_range(1, halt);
    m = (mid_start && L > 1) ? 1 + hlast / 2 : -1;
    last_c = (a >= 0) ? a + 2 : halt + 1;

    for (int c = 0; c <= last_c; c++) begin
      bus.start      = (c == 0) || (c == m);
      bus.load_len   = (c == 0) ? 8'(len_in) : 8'($urandom);
      bus.run_cycles = (c == 0) ? 16'(ncyc) : 16'($urandom);
      bus.abort      = (c == a);
      bus.byte_valid = v_plan[c];
      bus.byte_in    = byte_plan[c];
      bus.alu_result = alu_plan[c];
      @(posedge clk);
      #1;
      e = c + 1;
      if (a >= 0 && e > a) begin
        exp_ready = 1'b0;
        exp_wr    = 1'b0;
        exp_rst   = 1'b1;
        exp_busy  = 1'b0;
        exp_valid = 1'b0;
        exp_res   = (a >= halt) ? res_exp : prev_result;
      end else begin
        exp_ready = (L > 0) && (e <= hlast);
        exp_wr    = (hs_idx[e - 1] >= 0);
        exp_rst   = !((e >= r) && (e < r + ncyc));
        exp_busy  = (e < halt);
        exp_valid = (e >= halt);
        exp_res   = (e >= halt) ? res_exp : prev_result;
      end
      check_eq("byte_ready", bus.byte_ready, exp_ready);
      check_eq("pm_wr_en", bus.pm_wr_en, exp_wr);
      check_eq("cpu_rst", bus.cpu_rst, exp_rst);
      check_eq("busy", bus.busy, exp_busy);
      check_eq("result_valid", bus.result_valid, exp_valid);
      check_eq("result_out", bus.result_out, exp_res);
      if (exp_wr) begin
        check_eq("pm_addr", bus.pm_addr, hs_idx[e - 1]);
        check_eq("pm_wdata", bus.pm_wdata, byte_plan[e - 1]);
      end
    end
    if (a < 0 || a >= halt) prev_result = res_exp;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.byte_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.load_len   = 8'd0;
    bus.run_cycles = 16'd0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    bus.alu_result = 8'h00;
    #1;
    check_reset("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst_held");
    rst = 1'b0;

    // Directed image, back-to-back bytes, three run cycles
    fixed_bytes[0] = 8'h13;
    fixed_bytes[1] = 8'h05;
    fixed_bytes[2] = 8'h50;
    fixed_bytes[3] = 8'h00;
    use_fixed = 1'b1;
    run_seq(4, 3, 0, 0, 1'b0);
    use_fixed = 1'b0;

    run_seq(3, 2, 2, 0, 1'b0);     // valid gaps 1,0,0,1,1
    run_seq(0, 2, 0, 0, 1'b0);     // skip LOAD
    run_seq(200, 4, 0, 0, 1'b1);   // clipped to 128, ignored mid-LOAD start
    run_seq(2, 0, 1, 0, 1'b0);     // zero-run after a load
    run_seq(0, 0, 0, 0, 1'b0);     // straight to HALT
    run_seq(5, 3, 1, 0, 1'b0);     // leaves a nonzero captured result
    run_seq(5, 10, 1, 1, 1'b0);    // abort on second RUN cycle

    // Async reset in the middle of LOAD, then reload from address 0
    bus.start      = 1'b1;
    bus.load_len   = 8'd4;
    bus.run_cycles = 16'd5;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'hA1;
    @(posedge clk);
    #1;
    bus.byte_in = 8'hA2;
    @(posedge clk);
    #1;
    check_eq("pre_rst_wr_en", bus.pm_wr_en, 1);
    check_eq("pre_rst_addr", bus.pm_addr, 1);
    check_eq("pre_rst_wdata", bus.pm_wdata, 8'hA2);
    #2;
    rst = 1'b1;
    #1;
    check_reset("rst_mid_load");
    @(posedge clk);
    #1;
    check_reset("rst_mid_load_held");
    bus.byte_valid = 1'b0;
    rst = 1'b0;
    prev_result = 8'h00;
    run_seq(4, 3, 0, 0, 1'b0);

    // Randomized sequences
    for (int i = 0; i < 10; i++) begin
      run_seq($urandom_range(0, 140), $urandom_range(0, 20), 1,
              ($urandom_range(0, 3) == 0) ? 2 : 0, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
